eight_bit_four_way_dispatch_controller: RTL

//  Sequences an 8-bit 1-to-4 demux datapath: accepts bytes on a valid/ready input, picks a destination

---
 rtl/eight_bit_four_way_dispatch_controller.sv | 88 ++++++++
 1 files changed

// File: rtl/eight_bit_four_way_dispatch_controller.sv
// Byte dispatcher: accepts valid/ready beats, picks a channel (addressed or round-robin over
// enabled channels) and holds the byte on that channel's bus until its sink is ready.
module eight_bit_four_way_dispatch_controller #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [3:0]        ch_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]        state;
  logic [DATA_W-1:0] held;
  logic [1:0]        rr_ptr;
  logic [1:0]        rr_base;
  logic [1:0]        rr_dest;
  logic [1:0]        dest;
  logic              complete;
  logic              dest_ok;
  logic              accept;

  assign busy     = (state == HOLD);
  assign complete = busy && out_ready[sel];

  // A beat accepted in the completing cycle searches from the already-advanced pointer.
  assign rr_base  = (mode && complete) ? sel + 2'd1 : rr_ptr;

  // Scan downward so the enabled channel closest to rr_base wins.
  always_comb begin
    rr_dest = rr_base;
    for (int i = 3; i >= 0; i--) begin
      if (ch_en[rr_base + 2'(i)]) rr_dest = rr_base + 2'(i);
    end
  end

  assign dest     = mode ? rr_dest : in_dest;
  assign dest_ok  = mode ? (|ch_en) : ch_en[in_dest];
  assign in_ready = (!busy || complete) && !(mode && (ch_en == 4'b0000));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      held     <= '0;
      sel      <= 2'd0;
      rr_ptr   <= 2'd0;
      drop_cnt <= '0;
    end else begin
      if (mode && complete) rr_ptr <= rr_base;
      if (accept && dest_ok) begin
        held  <= in_data;
        sel   <= dest;
        state <= HOLD;
      end else if (complete) begin
        state <= IDLE;
      end
      if (accept && !dest_ok && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    out_valid = busy ? (4'b0001 << sel) : 4'b0000;
    out1      = (busy && sel == 2'd0) ? held : '0;
    out2      = (busy && sel == 2'd1) ? held : '0;
    out3      = (busy && sel == 2'd2) ? held : '0;
    out4      = (busy && sel == 2'd3) ? held : '0;
  end

endmodule
